// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA sync generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // Every segment must exist and the whole period must fit the counter.
  function automatic bit axis_params_ok(input int active, input int front,
                                        input int sync, input int back);
    return (active > 0) && (front > 0) && (sync > 0) && (back > 0) &&
           (axis_total(active, front, sync, back) <= CNT_MAX);
  endfunction

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_sync_axis.sv
// One timing axis: a wrapping counter plus combinational decode of its
// sync and active regions. Used once per line and once per frame.
module vga_sync_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output cnt_t count_o,
  output logic wrap_o,
  output logic sync_n_o,
  output logic active_o
);

  localparam int   TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
  localparam cnt_t ACTIVE_END = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_FIRST = cnt_t'(ACTIVE + FRONT);
  localparam cnt_t SYNC_LAST  = cnt_t'(ACTIVE + FRONT + SYNC - 1);

  if (!axis_params_ok(ACTIVE, FRONT, SYNC, BACK)) begin : g_bad_params
    $error("vga_sync_axis: every segment must be non-zero and the total must not exceed 1024");
  end

  cnt_t count_q, count_d;
  logic at_last;

  always_comb begin
    at_last = (count_q == LAST);
    count_d = count_q;
    if (enable_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = enable_i && at_last;
  assign sync_n_o = !((count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST));
  assign active_o = (count_q < ACTIVE_END);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync generator: horizontal and vertical axes with every output
// registered from the current (h,v) position, one clock behind it.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic             i_clk_25MHz,
  input  logic             i_rst_n,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_display_en,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_line_start,
  output logic             o_frame_start
);

  cnt_t h_count, v_count;
  logic h_wrap, h_sync_n, h_active;
  logic v_wrap_unused, v_sync_n, v_active;

  vga_sync_axis #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk_i    (i_clk_25MHz),
    .rst_ni   (i_rst_n),
    .enable_i (1'b1),
    .count_o  (h_count),
    .wrap_o   (h_wrap),
    .sync_n_o (h_sync_n),
    .active_o (h_active)
  );

  // The frame counter only steps on the clock where the line counter wraps.
  vga_sync_axis #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk_i    (i_clk_25MHz),
    .rst_ni   (i_rst_n),
    .enable_i (h_wrap),
    .count_o  (v_count),
    .wrap_o   (v_wrap_unused),
    .sync_n_o (v_sync_n),
    .active_o (v_active)
  );

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  cnt_t x_q, x_d;
  cnt_t y_q, y_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = h_sync_n;
    vsync_d       = v_sync_n;
    de_d          = h_active && v_active;
    x_d           = de_d ? h_count : '0;
    y_d           = de_d ? v_count : '0;
    line_start_d  = (h_count == '0);
    frame_start_d = (h_count == '0) && (v_count == '0);
  end

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_display_en  = de_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a default 640x480 instance for line-level
// timing and a tiny-geometry instance for whole-frame behaviour.
module tb_vga_sync_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d_n, rst_s_n;
  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  int checks = 0;
  int errors = 0;

  vga_sync_generator dut_d (
    .i_clk_25MHz  (clk),
    .i_rst_n      (rst_d_n),
    .o_hsync      (d_hs),
    .o_vsync      (d_vs),
    .o_display_en (d_de),
    .o_x          (d_x),
    .o_y          (d_y),
    .o_line_start (d_ls),
    .o_frame_start(d_fs)
  );

  // Small geometry: H 8/2/3/2 (total 15, hsync h=10..12), V 4/1/2/1 (total 8, vsync v=5..6)
  localparam int SH_T = 15;
  localparam int SV_T = 8;
  localparam int S_FRAME = SH_T * SV_T;

  vga_sync_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .i_clk_25MHz  (clk),
    .i_rst_n      (rst_s_n),
    .o_hsync      (s_hs),
    .o_vsync      (s_vs),
    .o_display_en (s_de),
    .o_x          (s_x),
    .o_y          (s_y),
    .o_line_start (s_ls),
    .o_frame_start(s_fs)
  );

  typedef struct {
    int pos;
    int hs, vs, de, x, y, ls, fs;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic chk_reset(input string tag, input logic hs, input logic vs, input logic de,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic ls, input logic fs);
    chk({tag, "_hsync"}, int'(hs), 1);
    chk({tag, "_vsync"}, int'(vs), 1);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_line_start"}, int'(ls), 0);
    chk({tag, "_frame_start"}, int'(fs), 0);
  endtask

  initial begin
    int pos;
    int hs_first, hs_last, hs_cnt, de_cnt, ls_cnt, x_bad, y_bad;
    int mism, fs_cnt, fs_misplaced, s_ls_cnt, vs_cnt, vs_first, vs_first_ls, max_y;
    int h, v, e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs;

    //           pos   hs vs de  x    y  ls fs
    vecs[0]  = '{0,    1, 1, 1, 0,   0, 1, 1};
    vecs[1]  = '{1,    1, 1, 1, 1,   0, 0, 0};
    vecs[2]  = '{639,  1, 1, 1, 639, 0, 0, 0};
    vecs[3]  = '{640,  1, 1, 0, 0,   0, 0, 0};
    vecs[4]  = '{655,  1, 1, 0, 0,   0, 0, 0};
    vecs[5]  = '{656,  0, 1, 0, 0,   0, 0, 0};
    vecs[6]  = '{751,  0, 1, 0, 0,   0, 0, 0};
    vecs[7]  = '{752,  1, 1, 0, 0,   0, 0, 0};
    vecs[8]  = '{799,  1, 1, 0, 0,   0, 0, 0};
    vecs[9]  = '{800,  1, 1, 1, 0,   1, 1, 0};
    vecs[10] = '{805,  1, 1, 1, 5,   1, 0, 0};
    vecs[11] = '{1610, 1, 1, 1, 10,  2, 0, 0};

    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) tick();
    chk_reset("reset_d", d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs);
    chk_reset("reset_s", s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs);

    // Table: outputs after the k-th released edge reflect position k-1.
    rst_d_n = 1'b1;
    tick();
    pos = 0;
    foreach (vecs[i]) begin
      while (pos < vecs[i].pos) begin
        tick();
        pos++;
      end
      chk($sformatf("vec%0d_p%0d_hsync", i, pos), int'(d_hs), vecs[i].hs);
      chk($sformatf("vec%0d_p%0d_vsync", i, pos), int'(d_vs), vecs[i].vs);
      chk($sformatf("vec%0d_p%0d_de", i, pos), int'(d_de), vecs[i].de);
      chk($sformatf("vec%0d_p%0d_x", i, pos), int'(d_x), vecs[i].x);
      chk($sformatf("vec%0d_p%0d_y", i, pos), int'(d_y), vecs[i].y);
      chk($sformatf("vec%0d_p%0d_line_start", i, pos), int'(d_ls), vecs[i].ls);
      chk($sformatf("vec%0d_p%0d_frame_start", i, pos), int'(d_fs), vecs[i].fs);
    end

    // One full default line from a fresh reset.
    rst_d_n = 1'b0;
    tick();
    rst_d_n = 1'b1;
    hs_first = -1; hs_last = -1; hs_cnt = 0; de_cnt = 0; ls_cnt = 0; x_bad = 0; y_bad = 0;
    for (int p = 0; p < 800; p++) begin
      tick();
      if (!d_hs) begin
        if (hs_first < 0) hs_first = p;
        hs_last = p;
        hs_cnt++;
      end
      if (d_de) begin
        de_cnt++;
        if (int'(d_x) != p) x_bad++;
      end else if (d_x != 10'd0) begin
        x_bad++;
      end
      if (d_y != 10'd0) y_bad++;
      if (d_ls) ls_cnt++;
    end
    chk("line_hsync_start", hs_first, 656);
    chk("line_hsync_len", hs_cnt, 96);
    chk("line_hsync_span", hs_last - hs_first + 1, 96);
    chk("line_de_len", de_cnt, 640);
    chk("line_x_errors", x_bad, 0);
    chk("line_y_errors", y_bad, 0);
    chk("line_start_count", ls_cnt, 1);

    // Reset at h=700 on the default instance.
    rst_d_n = 1'b0;
    tick();
    rst_d_n = 1'b1;
    for (int p = 0; p < 700; p++) tick();
    chk("d_pre_reset_hsync_p699", int'(d_hs), 0);
    rst_d_n = 1'b0;
    tick();
    chk_reset("d_midline_reset", d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs);
    rst_d_n = 1'b1;
    tick();
    chk("d_release_frame_start", int'(d_fs), 1);
    chk("d_release_line_start", int'(d_ls), 1);
    chk("d_release_de", int'(d_de), 1);

    // Two full small frames plus one position, compared against a position model.
    rst_s_n = 1'b1;
    mism = 0; fs_cnt = 0; fs_misplaced = 0; s_ls_cnt = 0; vs_cnt = 0;
    vs_first = -1; vs_first_ls = 0; max_y = 0;
    for (int p = 0; p <= 2 * S_FRAME; p++) begin
      tick();
      h = p % SH_T;
      v = (p / SH_T) % SV_T;
      e_hs = (h >= 10 && h <= 12) ? 0 : 1;
      e_vs = (v >= 5 && v <= 6) ? 0 : 1;
      e_de = (h < 8 && v < 4) ? 1 : 0;
      e_x  = e_de ? h : 0;
      e_y  = e_de ? v : 0;
      e_ls = (h == 0) ? 1 : 0;
      e_fs = (h == 0 && v == 0) ? 1 : 0;
      if (int'(s_hs) != e_hs || int'(s_vs) != e_vs || int'(s_de) != e_de ||
          int'(s_x) != e_x || int'(s_y) != e_y || int'(s_ls) != e_ls || int'(s_fs) != e_fs)
        mism++;
      if (s_fs) begin
        fs_cnt++;
        if (p % S_FRAME != 0) fs_misplaced++;
      end
      if (p < S_FRAME) begin
        if (s_ls) s_ls_cnt++;
        if (!s_vs) begin
          if (vs_first < 0) begin
            vs_first = p;
            vs_first_ls = int'(s_ls);
          end
          vs_cnt++;
        end
      end
      if (s_de && int'(s_y) > max_y) max_y = int'(s_y);
      if (p == S_FRAME) begin
        chk("s_wrap_frame_start", int'(s_fs), 1);
        chk("s_wrap_x", int'(s_x), 0);
        chk("s_wrap_y", int'(s_y), 0);
        chk("s_wrap_de", int'(s_de), 1);
      end
    end
    chk("s_model_mismatches", mism, 0);
    chk("s_frame_start_count", fs_cnt, 3);
    chk("s_frame_start_misplaced", fs_misplaced, 0);
    chk("s_line_starts_per_frame", s_ls_cnt, SV_T);
    chk("s_vsync_low_clocks", vs_cnt, 2 * SH_T);
    chk("s_vsync_first_pos", vs_first, 5 * SH_T);
    chk("s_vsync_first_on_line_start", vs_first_ls, 1);
    chk("s_max_y_while_de", max_y, 3);

    // Mid-frame reset with the counter at (h=11, v=5), inside both sync pulses.
    rst_s_n = 1'b0;
    tick();
    rst_s_n = 1'b1;
    for (int p = 0; p < 5 * SH_T + 11; p++) tick();
    chk("s_pre_reset_hsync", int'(s_hs), 0);
    chk("s_pre_reset_vsync", int'(s_vs), 0);
    rst_s_n = 1'b0;
    tick();
    chk_reset("s_midframe_reset", s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs);
    rst_s_n = 1'b1;
    tick();
    chk("s_release_frame_start", int'(s_fs), 1);
    chk("s_release_line_start", int'(s_ls), 1);
    chk("s_release_de", int'(s_de), 1);
    tick();
    chk("s_release_next_x", int'(s_x), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
